im_loader: RTL and testbench
============================

IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 i_start  input  1  one-cycle pulse that starts a load session; sampled only in IDLE or DONE.
REQ-005 i_base_addr  input  `IM_ADDR  byte start address in instruction memory.
REQ-006 i_word_count  input  16  number of 32-bit words to load; captured with i_start.
REQ-007 i_abort  input  1  terminates the current session.
REQ-008 i_valid  input  1  producer has a word on i_wdata.
REQ-009 i_wdata  input  `RNG_32  program word.
REQ-010 o_ready  output  1  loader accepts a word this cycle.
REQ-011 o_im_wen  output  `IM_DATA_BYTES  byte write enables to instruction memory.
REQ-012 o_im_addr  output  `IM_ADDR  write byte address to instruction memory.
REQ-013 o_im_wdata  output  `RNG_32  write data to instruction memory.
REQ-014 o_core_rst_n  output  1  active-low reset held on the core pipeline (IF stage onward).
REQ-015 o_busy  output  1  session in progress.
REQ-016 o_done  output  1  last session completed successfully (level).
REQ-017 o_err  output  1  last session ended in error or abort (level).

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, DONE and ERR.
REQ-019 IDLE -> LOAD on i_start when i_base_addr[1:0]==0 and i_word_count!=0.
REQ-020 IDLE -> ERR on i_start when the address is misaligned or the word count is 0.
REQ-021 LOAD -> DONE in the cycle after the beat that carries the last word is accepted.
REQ-022 LOAD -> ERR on i_abort; abort has priority over a same-cycle beat, and that beat SHALL NOT be written.
REQ-023 DONE/ERR -> LOAD or ERR on i_start, using the same checks as IDLE.
REQ-024 A beat SHALL be accepted when i_valid && o_ready.
REQ-025 o_ready SHALL be 1 only in LOAD, and SHALL be 0 in the cycle that the FSM enters LOAD.
REQ-026 Write latency: an accepted beat SHALL drive o_im_wen=all-ones, o_im_addr=current address and o_im_wdata=i_wdata registered one cycle later.
REQ-027 o_im_wen SHALL be 0 in every other cycle, so exactly one write occurs per beat.
REQ-028 The address counter SHALL load i_base_addr on start and increment by 4 per accepted beat.
REQ-029 The word counter SHALL load i_word_count on start and decrement by 1 per accepted beat.
REQ-030 Overflow: a session whose last address (i_base_addr + 4*(count-1)) exceeds 2^`IM_ADDR-4 SHALL go to ERR at start, and no write SHALL be issued.
REQ-031 Overflow check arithmetic SHALL be performed at `IM_ADDR+18 bits so that it cannot wrap.
REQ-032 o_core_rst_n SHALL be 0 in IDLE, LOAD and ERR, and 1 only in DONE.
REQ-033 On entering LOAD from DONE, o_core_rst_n SHALL drop in the same cycle that the state changes.
REQ-034 o_busy SHALL equal (state==LOAD).
REQ-035 o_done SHALL equal (state==DONE).
REQ-036 o_err SHALL equal (state==ERR).
REQ-037 i_start SHALL be ignored while in LOAD.
REQ-038 i_abort SHALL be ignored outside LOAD.
REQ-039 i_valid SHALL be ignored outside LOAD.
REQ-040 The last-beat write SHALL complete (REQ-026) before the cycle in which o_core_rst_n rises.

Reset
REQ-041 While rst_n=0, the module SHALL hold: state=IDLE, counters=0, o_im_wen=0, o_im_addr=0, o_im_wdata=0, o_ready=0, o_core_rst_n=0, o_busy=0, o_done=0, o_err=0.
REQ-042 Reset during LOAD SHALL discard the session, and any registered pending write SHALL NOT be emitted.

Structure
REQ-043 The state enum (IDLE/LOAD/DONE/ERR, 2 bits) SHALL be defined in the shared package riviera_pkg.
REQ-044 Widths SHALL come from defines.sv: `IM_ADDR, `IM_DATA_BYTES, `RNG_32.
REQ-045 The design SHALL be a single module with no sub-module; the counters and write register are inline.

Verification
REQ-046 The bench SHALL cover these directed scenarios:
- base=0x100, count=3, i_valid held high with data A,B,C -> writes at 0x100/0x104/0x108, wen=0xF each, no gaps; o_done=1 and o_core_rst_n=1 one cycle after the write to 0x108.
- base=0x100, count=4, i_valid toggling 1,0,1,0... -> exactly 4 writes in order, o_ready stays 1, o_done only after the 4th.
- Misaligned base=0x102, or count=0 -> o_err=1 next cycle, no wen pulse, o_core_rst_n stays 0.
- base=2^`IM_ADDR-8, count=3 -> ERR at start, zero writes.
- count=5, i_abort together with the 3rd beat -> 2 writes only, o_err=1.
- In DONE, new i_start with base=0x0, count=1 -> o_core_rst_n falls the same cycle, rises after the write.
- rst_n pulsed low mid-LOAD -> all outputs at reset values immediately, no further writes.

Source files
------------

// File: rtl/riviera_pkg.sv
// Shared types, widths and the session admission check for the IM loader.
`ifndef IM_DEFINES_SV
`include "defines.sv"
`endif

package riviera_pkg;

   localparam int IM_ADDR_W = `IM_ADDR;
   localparam int IM_BYTES  = `IM_DATA_BYTES;
   localparam int CHK_W     = `IM_ADDR + 18;

   typedef logic [`RNG_32] word_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } im_state_e;

   // Widened so base + 4*(count-1) can never wrap before the limit compare.
   function automatic logic start_ok(input logic [IM_ADDR_W-1:0] base,
                                     input logic [15:0]          count);
      logic [CHK_W-1:0] last_addr;
      logic [CHK_W-1:0] limit;
      last_addr = {18'b0, base} + ({{IM_ADDR_W{1'b0}}, count, 2'b00} - CHK_W'(4));
      limit     = CHK_W'((1 << IM_ADDR_W) - 4);
      return (base[1:0] == 2'b00) && (count != 16'd0) && (last_addr <= limit);
   endfunction

endpackage

// File: rtl/im_loader_if.sv
// Control, stream and memory-write signals of the loader; master = host/producer side.
interface im_loader_if import riviera_pkg::*; ();

   logic                 i_start;
   logic [IM_ADDR_W-1:0] i_base_addr;
   logic [15:0]          i_word_count;
   logic                 i_abort;
   logic                 i_valid;
   word_t                i_wdata;
   logic                 o_ready;
   logic [IM_BYTES-1:0]  o_im_wen;
   logic [IM_ADDR_W-1:0] o_im_addr;
   word_t                o_im_wdata;
   logic                 o_core_rst_n;
   logic                 o_busy;
   logic                 o_done;
   logic                 o_err;

   modport master (
      output i_start, i_base_addr, i_word_count, i_abort, i_valid, i_wdata,
      input  o_ready, o_im_wen, o_im_addr, o_im_wdata, o_core_rst_n,
             o_busy, o_done, o_err
   );

   modport slave (
      input  i_start, i_base_addr, i_word_count, i_abort, i_valid, i_wdata,
      output o_ready, o_im_wen, o_im_addr, o_im_wdata, o_core_rst_n,
             o_busy, o_done, o_err
   );

endinterface

// File: rtl/defines.sv
// Global width macros shared by the instruction-memory loader and its package.
`ifndef IM_DEFINES_SV
`define IM_DEFINES_SV
`define IM_ADDR 12
`define IM_DATA_BYTES 4
`define RNG_32 31:0
`endif

// File: rtl/im_loader.sv
// Streams program words into instruction memory and holds the core in reset
// until a complete, in-range image has been written.
module im_loader import riviera_pkg::*; (
   input  logic        clk,
   input  logic        rst_n,
   im_loader_if.slave  bus
);

   im_state_e            state_reg, state_next;
   logic                 entry_reg;
   logic [IM_ADDR_W-1:0] addr_reg;
   logic [15:0]          cnt_reg;
   logic [IM_BYTES-1:0]  wen_reg;
   logic [IM_ADDR_W-1:0] waddr_reg;
   word_t                wdata_reg;

   logic ready;
   logic accept;
   logic start_good;

   assign start_good = start_ok(bus.i_base_addr, bus.i_word_count);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Abort wins over a same-cycle beat; a zero counter means the last write is
   // already on the memory port, so DONE follows one cycle after that beat.
   always_comb begin
      state_next = state_reg;
      ready      = 1'b0;
      accept     = 1'b0;
      case (state_reg)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (bus.i_start) begin
               state_next = start_good ? ST_LOAD : ST_ERR;
            end
         end
         ST_LOAD: begin
            ready = !entry_reg && (cnt_reg != 16'd0);
            if (bus.i_abort) begin
               state_next = ST_ERR;
            end else begin
               accept = ready && bus.i_valid;
               if (cnt_reg == 16'd0) begin
                  state_next = ST_DONE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_reg <= 1'b0;
         addr_reg  <= '0;
         cnt_reg   <= '0;
         wen_reg   <= '0;
         waddr_reg <= '0;
         wdata_reg <= '0;
      end else begin
         entry_reg <= (state_next == ST_LOAD) && (state_reg != ST_LOAD);
         wen_reg   <= accept ? '1 : '0;
         if (accept) begin
            waddr_reg <= addr_reg;
            wdata_reg <= bus.i_wdata;
         end
         if ((state_reg != ST_LOAD) && bus.i_start && start_good) begin
            addr_reg <= bus.i_base_addr;
            cnt_reg  <= bus.i_word_count;
         end else if (accept) begin
            addr_reg <= addr_reg + IM_ADDR_W'(4);
            cnt_reg  <= cnt_reg - 16'd1;
         end
      end
   end

   assign bus.o_ready      = ready;
   assign bus.o_im_wen     = wen_reg;
   assign bus.o_im_addr    = waddr_reg;
   assign bus.o_im_wdata   = wdata_reg;
   assign bus.o_core_rst_n = (state_reg == ST_DONE);
   assign bus.o_busy       = (state_reg == ST_LOAD);
   assign bus.o_done       = (state_reg == ST_DONE);
   assign bus.o_err        = (state_reg == ST_ERR);

endmodule

// File: tb/tb_im_loader.sv
// Directed and randomized load sessions for im_loader, checked against a
// session-level model of expected writes and final status.
module tb_im_loader;
   import riviera_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic done_prev = 1'b0;

   logic [IM_ADDR_W-1:0] w_addr_q[$];
   logic [31:0]          w_data_q[$];
   logic [IM_BYTES-1:0]  w_wen_q[$];
   int                   w_cyc_q[$];
   int                   done_q[$];

   im_loader_if bus();

   im_loader dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && bus.o_im_wen != '0) begin
         w_addr_q.push_back(bus.o_im_addr);
         w_data_q.push_back(bus.o_im_wdata);
         w_wen_q.push_back(bus.o_im_wen);
         w_cyc_q.push_back(cyc);
      end
      if (rst_n && bus.o_done && !done_prev) done_q.push_back(cyc);
      done_prev <= bus.o_done;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      w_addr_q.delete();
      w_data_q.delete();
      w_wen_q.delete();
      w_cyc_q.delete();
      done_q.delete();
   endtask

   // mode 0: valid always high, 1: toggling, 2: random.
   // stop_after >= 0 leaves the session mid-LOAD right after that many beats.
   task automatic run_session(input string name, input logic [IM_ADDR_W-1:0] base,
                              input logic [15:0] cnt, input int mode,
                              input int abort_at, input int stop_after,
                              output int accepted);
      logic [31:0] data[$];
      longint      last;
      bit          exp_ok, aborted, v, rdy;
      int          idx, iter;
      last   = longint'(base) + 4 * (longint'(cnt) - 1);
      exp_ok = (base % 4 == 0) && (cnt != 0) && (last <= (longint'(1) << IM_ADDR_W) - 4);
      for (int i = 0; i < int'(cnt); i++) data.push_back($urandom);
      clear_log();
      bus.i_base_addr  = base;
      bus.i_word_count = cnt;
      bus.i_start      = 1'b1;
      step();
      bus.i_start = 1'b0;
      check({name, "_start_status"}, {bus.o_busy, bus.o_err, bus.o_done, bus.o_core_rst_n},
            {exp_ok, !exp_ok, 1'b0, 1'b0});
      accepted = 0;
      if (!exp_ok) begin
         repeat (4) step();
         check({name, "_err_writes"}, w_addr_q.size(), 0);
         check({name, "_err_hold"}, {bus.o_err, bus.o_core_rst_n}, 2'b10);
         $display("session %s base=0x%0h count=%0d -> rejected", name, base, cnt);
         return;
      end
      idx = 0; iter = 0; aborted = 0;
      while (idx < int'(cnt) && !aborted && !(stop_after >= 0 && idx == stop_after) && iter < 200) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (iter % 2 == 1);
            default: v = 1'($urandom_range(0, 1));
         endcase
         bus.i_valid = v;
         bus.i_wdata = data[idx];
         bus.i_abort = (idx == abort_at) && v;
         @(negedge clk);
         rdy = bus.o_ready;
         if (iter > 0) check($sformatf("%s_ready_it%0d", name, iter), rdy, 1'b1);
         step();
         if (bus.i_abort) aborted = 1;
         else if (v && rdy) idx++;
         iter++;
      end
      bus.i_valid = 1'b0;
      bus.i_abort = 1'b0;
      bus.i_wdata = $urandom;
      if (iter >= 200) check({name, "_timeout"}, iter, 0);
      accepted = idx;
      if (stop_after >= 0) return;
      repeat (4) step();
      check({name, "_nwrites"}, w_addr_q.size(), idx);
      for (int k = 0; k < idx && k < w_addr_q.size(); k++) begin
         check($sformatf("%s_wr%0d_addr", name, k), w_addr_q[k], base + IM_ADDR_W'(4 * k));
         check($sformatf("%s_wr%0d_data", name, k), w_data_q[k], data[k]);
         check($sformatf("%s_wr%0d_wen", name, k), w_wen_q[k], {IM_BYTES{1'b1}});
         if (mode == 0 && k > 0)
            check($sformatf("%s_wr%0d_gap", name, k), w_cyc_q[k] - w_cyc_q[k-1], 1);
      end
      if (aborted) begin
         check({name, "_abort_status"}, {bus.o_busy, bus.o_err, bus.o_done, bus.o_core_rst_n}, 4'b0100);
      end else begin
         check({name, "_done_status"}, {bus.o_busy, bus.o_err, bus.o_done, bus.o_core_rst_n}, 4'b0011);
         check({name, "_done_rises"}, done_q.size(), 1);
         if (done_q.size() == 1 && w_cyc_q.size() == idx && idx > 0)
            check({name, "_done_latency"}, done_q[0] - w_cyc_q[idx-1], 1);
      end
      $display("session %s base=0x%0h count=%0d mode=%0d -> %0d writes, aborted=%0d",
               name, base, cnt, mode, w_addr_q.size(), aborted);
   endtask

   initial begin
      int acc;
      logic [IM_ADDR_W-1:0] rb;
      logic [15:0] rc;
      rst_n = 1'b0;
      bus.i_start = 1'b0; bus.i_base_addr = '0; bus.i_word_count = '0;
      bus.i_abort = 1'b0; bus.i_valid = 1'b0; bus.i_wdata = '0;
      repeat (2) step();
      check("reset_outputs", {bus.o_ready, bus.o_im_wen, bus.o_im_addr, bus.o_im_wdata,
                              bus.o_core_rst_n, bus.o_busy, bus.o_done, bus.o_err}, 64'd0);
      rst_n = 1'b1;
      step();

      run_session("burst3", 12'h100, 16'd3, 0, -1, -1, acc);
      run_session("toggle4", 12'h100, 16'd4, 1, -1, -1, acc);

      // In DONE, abort and valid must have no effect.
      clear_log();
      bus.i_abort = 1'b1; bus.i_valid = 1'b1; bus.i_wdata = 32'hDEAD_BEEF;
      repeat (2) step();
      bus.i_abort = 1'b0; bus.i_valid = 1'b0;
      check("done_ignores_abort", {bus.o_done, bus.o_err, bus.o_core_rst_n}, 3'b101);
      check("done_ignores_valid", w_addr_q.size(), 0);
      $display("idle-input test in DONE -> %0d writes", w_addr_q.size());

      check("restart_pre_core_rst", bus.o_core_rst_n, 1'b1);
      run_session("restart1", 12'h000, 16'd1, 0, -1, -1, acc);

      run_session("misaligned", 12'h102, 16'd2, 0, -1, -1, acc);
      run_session("count0", 12'h100, 16'd0, 0, -1, -1, acc);
      run_session("overflow", IM_ADDR_W'((1 << IM_ADDR_W) - 8), 16'd3, 0, -1, -1, acc);
      run_session("top_fit", IM_ADDR_W'((1 << IM_ADDR_W) - 8), 16'd2, 0, -1, -1, acc);
      run_session("abort3", 12'h040, 16'd5, 0, 2, -1, acc);

      for (int s = 0; s < 8; s++) begin
         rb = IM_ADDR_W'($urandom_range(0, (1 << IM_ADDR_W) / 4 - 1) * 4);
         if ($urandom_range(0, 4) == 0) rb[1:0] = 2'($urandom_range(1, 3));
         rc = 16'($urandom_range(0, 10));
         run_session($sformatf("rand%0d", s), rb, rc, int'($urandom_range(0, 2)), -1, -1, acc);
      end

      run_session("rst_mid", 12'h200, 16'd5, 0, -1, 3, acc);
      rst_n = 1'b0;
      #1;
      check("rst_mid_outputs", {bus.o_ready, bus.o_im_wen, bus.o_im_addr, bus.o_im_wdata,
                                bus.o_core_rst_n, bus.o_busy, bus.o_done, bus.o_err}, 64'd0);
      step();
      rst_n = 1'b1;
      repeat (4) step();
      check("rst_mid_writes", w_addr_q.size(), acc - 1);
      check("rst_mid_status", {bus.o_busy, bus.o_done, bus.o_err, bus.o_core_rst_n}, 4'b0000);
      $display("session rst_mid: reset after %0d beats -> %0d writes", acc, w_addr_q.size());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
